ms_wdt_win: RTL and testbench
=============================

MS_WDT_WIN -- requirements
Module: ms_wdt_win

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the timeout counter width in bits (legal range 8..32).
REQ-002 The block SHALL have parameter PW, default 8, meaning the prescaler width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as in the rest of the codebase.
REQ-004 The block SHALL have the port clk, input, width 1, meaning the single clock; all flops are on the rising edge.
REQ-005 The block SHALL have the port rst_n, input, width 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have the port en, input, width 1, meaning watchdog enable (level).
REQ-007 The block SHALL have the port load, input, width W, meaning the timeout reload value.
REQ-008 The block SHALL have the port presc, input, width PW, meaning the prescale divisor minus 1; a tick occurs every presc+1 cycles.
REQ-009 The block SHALL have the port win_en, input, width 1, meaning window mode enable.
REQ-010 The block SHALL have the port window, input, width W, meaning the open-window threshold; a feed is legal only when count <= window.
REQ-011 The block SHALL have the port feed, input, width 1, meaning a single-cycle kick pulse.
REQ-012 The block SHALL have the port irq_clr, input, width 1, meaning clear of the sticky early-warning flag.
REQ-013 The block SHALL have the port count, output, width W, meaning the current timer value.
REQ-014 The block SHALL have the port irq, output, width 1, meaning the sticky stage-1 timeout warning.
REQ-015 The block SHALL have the port wdt_rst, output, width 1, meaning the stage-2 bite (system reset request).
REQ-016 The block SHALL have the port win_err, output, width 1, meaning sticky: the bite was caused by an early feed.
REQ-017 The block SHALL have the port state, output, width 2, meaning the FSM state encoding.

Function
REQ-018 The FSM SHALL have states IDLE=0, RUN=1, WARN=2, BITE=3, all registered.
REQ-019 In IDLE, count SHALL register load every cycle and the prescaler SHALL be held at 0; IDLE->RUN when en=1.
REQ-020 The prescaler SHALL count 0..presc and assert a one-cycle tick when it equals presc, then wrap to 0; presc=0 SHALL give a tick every cycle.
REQ-021 In RUN/WARN, count SHALL decrement by 1 on each tick while count != 0.
REQ-022 A tick with count==0 in RUN SHALL go to WARN, reload count with load, and set irq in the same edge.
REQ-023 A tick with count==0 in WARN SHALL go to BITE.
REQ-024 A legal feed (win_en=0, or count <= window) in RUN/WARN SHALL reload count with load, clear the prescaler, and go to RUN; irq is not cleared by a feed.
REQ-025 An illegal feed (win_en=1 and count > window) in RUN/WARN SHALL go to BITE and set win_err.
REQ-026 On a simultaneous legal feed and expiry tick, the feed SHALL win.
REQ-027 If en=0 in RUN/WARN, the FSM SHALL return to IDLE next edge; irq SHALL hold its value.
REQ-028 BITE SHALL be exited only by rst_n; wdt_rst=1 exactly while state==BITE; en, feed, and irq_clr SHALL be ignored in BITE except that irq_clr still clears irq.
REQ-029 irq_clr SHALL clear irq next edge; set SHALL win over a simultaneous clear.
REQ-030 load=0 SHALL cause expiry on the first tick after entry or reload.
REQ-031 load, window, and presc SHALL be sampled live; a change takes effect at the next reload or comparison.

Reset
REQ-032 While rst_n=0, the outputs SHALL be state=IDLE, count=0, irq=0, wdt_rst=0, win_err=0, and the prescaler SHALL be 0, all asynchronously.
REQ-033 Reset assertion mid-BITE or mid-count SHALL abort immediately, with no residual bite.

Structure
REQ-034 Package ms_wdt_pkg SHALL hold the state typedef/encodings and the default W/PW constants.
REQ-035 The prescaler SHALL be the sub-module ms_wdt_presc (params PW; ports clk, rst_n, clr, presc, tick).
REQ-036 The remaining FSM, counter, and flags SHALL stay in ms_wdt_win, with no latches, no combinational loops, and no derived clocks.

Verification
REQ-037 The bench SHALL cover: W=32, presc=0, load=5, en=1, no feed -> irq rises 6 cycles after RUN entry, and wdt_rst rises 6 ticks later, then holds until rst_n.
REQ-038 The bench SHALL cover: presc=3, load=2 -> count changes only every 4th cycle, and irq occurs after 12 cycles.
REQ-039 The bench SHALL cover: win_en=1, window=3, load=10 -> feed at count=7 gives BITE with win_err=1, and feed at count=3 gives reload to 10 in RUN.
REQ-040 The bench SHALL cover: in WARN, a legal feed returns to RUN with irq still 1; irq_clr then gives irq=0; irq_clr coincident with the stage-1 expiry gives irq=1.
REQ-041 The bench SHALL cover: en dropped in WARN -> IDLE with count==load; rst_n pulsed in BITE -> all outputs 0 asynchronously.
REQ-042 The bench SHALL cover: load=0 -> WARN on the first tick and BITE on the second; a feed coincident with the expiry tick gives RUN, not WARN.

Source files
------------

// File: rtl/ms_wdt_pkg.sv
// Shared types and default sizes for the windowed watchdog.
package ms_wdt_pkg;

   localparam int unsigned WDT_W_DEF  = 32;
   localparam int unsigned WDT_PW_DEF = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StWarn = 2'd2,
      StBite = 2'd3
   } wdt_state_e;

endpackage

// File: rtl/ms_wdt_presc.sv
// Prescaler: counts 0..presc and emits a one-cycle tick on the presc value.
module ms_wdt_presc
#(
   parameter int unsigned PW = ms_wdt_pkg::WDT_PW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [PW-1:0] presc,
   output logic          tick
);

   logic [PW-1:0] r_cnt;
   logic [PW-1:0] w_cnt_d;

   assign tick = (r_cnt == presc);

   // Next prescale value: wrap on tick, forced to 0 by clr.
   always_comb begin
      w_cnt_d = r_cnt + PW'(1);
      if (clr || tick) begin
         w_cnt_d = '0;
      end
   end

   // Prescale counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

endmodule

// File: rtl/ms_wdt_win.sv
// Two-stage windowed watchdog: warn irq on first expiry, bite on second
// expiry or on a feed arriving before the window opens.
module ms_wdt_win
   import ms_wdt_pkg::*;
#(
   parameter int unsigned W  = WDT_W_DEF,
   parameter int unsigned PW = WDT_PW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [W-1:0]  load,
   input  logic [PW-1:0] presc,
   input  logic          win_en,
   input  logic [W-1:0]  window,
   input  logic          feed,
   input  logic          irq_clr,
   output logic [W-1:0]  count,
   output logic          irq,
   output logic          wdt_rst,
   output logic          win_err,
   output logic [1:0]    state
);

   wdt_state_e r_state;
   wdt_state_e w_state_d;
   logic [W-1:0] r_count;
   logic [W-1:0] w_count_d;
   logic         r_irq;
   logic         w_irq_d;
   logic         r_win_err;
   logic         w_win_err_d;
   logic         w_tick;
   logic         w_presc_clr;
   logic         w_irq_set;
   logic         w_feed_ok;
   logic         w_zero;

   assign w_feed_ok = !win_en || (r_count <= window);
   assign w_zero    = (r_count == '0);

   ms_wdt_presc #(
      .PW (PW)
   ) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_presc_clr),
      .presc (presc),
      .tick  (w_tick)
   );

   // Next-state, counter and flag logic; en drop beats feed, feed beats expiry.
   always_comb begin
      w_state_d   = r_state;
      w_count_d   = r_count;
      w_presc_clr = 1'b0;
      w_irq_set   = 1'b0;
      w_win_err_d = r_win_err;
      case (r_state)
         StIdle: begin
            w_count_d   = load;
            w_presc_clr = 1'b1;
            if (en) begin
               w_state_d = StRun;
            end
         end
         StRun, StWarn: begin
            if (!en) begin
               w_state_d   = StIdle;
               w_count_d   = load;
               w_presc_clr = 1'b1;
            end else if (feed && w_feed_ok) begin
               w_state_d   = StRun;
               w_count_d   = load;
               w_presc_clr = 1'b1;
            end else if (feed) begin
               w_state_d   = StBite;
               w_win_err_d = 1'b1;
               w_presc_clr = 1'b1;
            end else if (w_tick) begin
               if (!w_zero) begin
                  w_count_d = r_count - W'(1);
               end else if (r_state == StRun) begin
                  w_state_d = StWarn;
                  w_count_d = load;
                  w_irq_set = 1'b1;
               end else begin
                  w_state_d   = StBite;
                  w_presc_clr = 1'b1;
               end
            end
         end
         StBite: begin
            // Only rst_n leaves this state.
            w_presc_clr = 1'b1;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      // Set has priority over a coincident clear.
      w_irq_d = w_irq_set ? 1'b1 : (irq_clr ? 1'b0 : r_irq);
   end

   // State, counter and sticky flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_count   <= '0;
         r_irq     <= 1'b0;
         r_win_err <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_count   <= w_count_d;
         r_irq     <= w_irq_d;
         r_win_err <= w_win_err_d;
      end
   end

   assign count   = r_count;
   assign irq     = r_irq;
   assign wdt_rst = (r_state == StBite);
   assign win_err = r_win_err;
   assign state   = r_state;

endmodule

// File: tb/tb_ms_wdt_win.sv
// Directed self-checking bench for the windowed watchdog.
module tb_ms_wdt_win;

   localparam int unsigned W  = 32;
   localparam int unsigned PW = 8;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [W-1:0]  load;
   logic [PW-1:0] presc;
   logic          win_en;
   logic [W-1:0]  window;
   logic          feed;
   logic          irq_clr;
   logic [W-1:0]  count;
   logic          irq;
   logic          wdt_rst;
   logic          win_err;
   logic [1:0]    state;

   int checks;
   int errors;

   ms_wdt_win #(
      .W  (W),
      .PW (PW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .presc   (presc),
      .win_en  (win_en),
      .window  (window),
      .feed    (feed),
      .irq_clr (irq_clr),
      .count   (count),
      .irq     (irq),
      .wdt_rst (wdt_rst),
      .win_err (win_err),
      .state   (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; releases reset on the falling edge.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #2;
      chk({tag, "_rst_state"},   32'(state),   32'd0);
      chk({tag, "_rst_count"},   count,        32'd0);
      chk({tag, "_rst_irq"},     32'(irq),     32'd0);
      chk({tag, "_rst_wdt_rst"}, 32'(wdt_rst), 32'd0);
      chk({tag, "_rst_win_err"}, 32'(win_err), 32'd0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      load    = 32'd5;
      presc   = 8'd0;
      win_en  = 1'b0;
      window  = 32'd0;
      feed    = 1'b0;
      irq_clr = 1'b0;

      // Reset state before any clock edge.
      #3;
      chk("init_state",   32'(state),   32'd0);
      chk("init_count",   count,        32'd0);
      chk("init_irq",     32'(irq),     32'd0);
      chk("init_wdt_rst", 32'(wdt_rst), 32'd0);
      chk("init_win_err", 32'(win_err), 32'd0);
      @(posedge clk);
      #5;
      rst_n = 1'b1;

      // presc=0, load=5: irq 6 cycles after RUN entry, bite 6 ticks later.
      step(1);
      chk("a_idle_load", count, 32'd5);
      en = 1'b1;
      step(1);
      chk("a_run_state", 32'(state), 32'd1);
      chk("a_run_count", count, 32'd5);
      step(5);
      chk("a_cnt0_state", 32'(state), 32'd1);
      chk("a_cnt0_count", count, 32'd0);
      chk("a_cnt0_irq",   32'(irq), 32'd0);
      step(1);
      chk("a_warn_state", 32'(state), 32'd2);
      chk("a_warn_irq",   32'(irq), 32'd1);
      chk("a_warn_count", count, 32'd5);
      step(5);
      chk("a_warn0_state", 32'(state), 32'd2);
      step(1);
      chk("a_bite_state",   32'(state), 32'd3);
      chk("a_bite_wdt_rst", 32'(wdt_rst), 32'd1);
      en   = 1'b0;
      feed = 1'b1;
      step(3);
      chk("a_bite_hold_state",   32'(state), 32'd3);
      chk("a_bite_hold_wdt_rst", 32'(wdt_rst), 32'd1);
      chk("a_bite_hold_irq",     32'(irq), 32'd1);
      feed    = 1'b0;
      irq_clr = 1'b1;
      step(1);
      irq_clr = 1'b0;
      chk("a_bite_irqclr_irq",   32'(irq), 32'd0);
      chk("a_bite_irqclr_state", 32'(state), 32'd3);
      pulse_reset("a");

      // presc=3, load=2: count moves every 4th cycle, irq after 12 cycles.
      step(1);
      chk("b_idle_load", count, 32'd5);
      presc = 8'd3;
      load  = 32'd2;
      step(1);
      chk("b_idle_reload", count, 32'd2);
      en = 1'b1;
      step(1);
      chk("b_run_count", count, 32'd2);
      step(3);
      chk("b_hold_count", count, 32'd2);
      step(1);
      chk("b_dec1_count", count, 32'd1);
      step(3);
      chk("b_hold1_count", count, 32'd1);
      step(1);
      chk("b_dec0_count", count, 32'd0);
      step(3);
      chk("b_pre_irq", 32'(irq), 32'd0);
      step(1);
      chk("b_warn_state", 32'(state), 32'd2);
      chk("b_warn_irq",   32'(irq), 32'd1);

      // Legal feed in WARN: back to RUN, irq stays set.
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("c_feed_state", 32'(state), 32'd1);
      chk("c_feed_irq",   32'(irq), 32'd1);
      chk("c_feed_count", count, 32'd2);
      irq_clr = 1'b1;
      step(1);
      irq_clr = 1'b0;
      chk("c_clr_irq", 32'(irq), 32'd0);
      step(2);
      chk("c_presc_restart", count, 32'd2);
      step(1);
      chk("c_dec1", count, 32'd1);
      step(4);
      chk("c_dec0", count, 32'd0);
      step(3);
      irq_clr = 1'b1;
      step(1);
      irq_clr = 1'b0;
      chk("c_setwins_state", 32'(state), 32'd2);
      chk("c_setwins_irq",   32'(irq), 32'd1);

      // en dropped in WARN: IDLE with count==load, irq held.
      en = 1'b0;
      step(1);
      chk("d_idle_state", 32'(state), 32'd0);
      chk("d_idle_count", count, 32'd2);
      chk("d_idle_irq",   32'(irq), 32'd1);
      irq_clr = 1'b1;
      step(1);
      irq_clr = 1'b0;
      chk("d_idle_irqclr", 32'(irq), 32'd0);

      // Window mode: early feed bites, feed inside window reloads.
      presc  = 8'd0;
      load   = 32'd10;
      win_en = 1'b1;
      window = 32'd3;
      step(1);
      chk("e_idle_load", count, 32'd10);
      en = 1'b1;
      step(1);
      chk("e_run_count", count, 32'd10);
      step(3);
      chk("e_count7", count, 32'd7);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("e_early_state",   32'(state), 32'd3);
      chk("e_early_win_err", 32'(win_err), 32'd1);
      chk("e_early_wdt_rst", 32'(wdt_rst), 32'd1);
      en = 1'b0;
      pulse_reset("e");
      step(1);
      en = 1'b1;
      step(1);
      chk("e2_run_count", count, 32'd10);
      step(7);
      chk("e2_count3", count, 32'd3);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("e2_feed_state",   32'(state), 32'd1);
      chk("e2_feed_count",   count, 32'd10);
      chk("e2_feed_win_err", 32'(win_err), 32'd0);
      step(1);
      chk("e2_after_feed", count, 32'd9);

      // load=0: WARN on first tick, BITE on second.
      en     = 1'b0;
      win_en = 1'b0;
      load   = 32'd0;
      step(1);
      chk("f_idle_count", count, 32'd0);
      en = 1'b1;
      step(1);
      chk("f_run_state", 32'(state), 32'd1);
      step(1);
      chk("f_warn_state", 32'(state), 32'd2);
      chk("f_warn_irq",   32'(irq), 32'd1);
      step(1);
      chk("f_bite_state", 32'(state), 32'd3);
      en = 1'b0;
      pulse_reset("f");
      step(1);
      en = 1'b1;
      step(1);
      chk("g_run_state", 32'(state), 32'd1);
      feed = 1'b1;
      step(1);
      feed = 1'b0;
      chk("g_feedwins_state", 32'(state), 32'd1);
      chk("g_feedwins_irq",   32'(irq), 32'd0);
      step(1);
      chk("g_next_warn", 32'(state), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
